// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames one payload per grant as ID, data MSB-first, CR, LF
// and feeds the bytes one at a time to a shared UART transmitter.
module uart_frame_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [7:0]  ID_BASE     = 8'h30,
    parameter int          GAP_CLKS    = 16,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [7:0]                      tx_byte_o,
    output logic                            tx_start_o,
    input  logic                            tx_busy_i,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
    output logic                            frame_active_o,
    output logic                            err_o
);

    localparam int GW         = $clog2(NUM_REQ);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int NUM_BYTES  = DATA_BYTES + 3;
    localparam int IW         = $clog2(NUM_BYTES);
    localparam int GCW        = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_BYTES - 1);
    localparam logic [IW-1:0]  CR_IDX   = IW'(DATA_BYTES + 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [TW-1:0]  TO_LAST  = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [GCW-1:0]        gap_q, gap_d;
    logic [TW-1:0]         to_q, to_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [7:0]            byte_q, byte_d;
    logic                  start_q, start_d;
    logic                  active_q, active_d;
    logic                  err_q, err_d;

    logic                  any_valid;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         cand;
    logic [DATA_WIDTH-1:0] slice;
    logic [7:0]            cur_byte;

    // Scan downward from the pointer so the nearest valid index wins last.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid_i[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == GW'(k)) begin
                slice = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        cur_byte = 8'h0A;
        if (idx_q == '0) begin
            cur_byte = ID_BASE + {{(8-GW){1'b0}}, grant_q};
        end else if (idx_q == CR_IDX) begin
            cur_byte = 8'h0D;
        end else begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (idx_q == IW'(b + 1)) begin
                    cur_byte = data_q[(DATA_BYTES-1-b)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        to_d     = to_q;
        ready_d  = '0;
        byte_d   = byte_q;
        start_d  = 1'b0;
        active_d = active_q;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    grant_d  = pick;
                    ready_d  = NUM_REQ'(1) << pick;
                    active_d = 1'b1;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                data_d  = slice;
                ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy_i) begin
                    start_d = 1'b1;
                    byte_d  = cur_byte;
                    to_d    = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (to_q == TO_LAST) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    if (idx_q == LAST_IDX) begin
                        active_d = 1'b0;
                        gap_d    = '0;
                        state_d  = S_GAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (GAP_CLKS == 0 || gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            to_q     <= '0;
            ready_q  <= '0;
            byte_q   <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
            ready_q  <= ready_d;
            byte_q   <= byte_d;
            start_q  <= start_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign tx_byte_o      = byte_q;
    assign tx_start_o     = start_q;
    assign grant_id_o     = grant_q;
    assign frame_active_o = active_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: vector table of RR grants plus
// hand-written busy-stall, ACK-timeout and mid-frame reset sequences.
module tb_uart_frame_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ready_o;
    logic [7:0]   tx_byte_o;
    logic         tx_start_o;
    logic         tx_busy_i;
    logic [1:0]   grant_id_o;
    logic         frame_active_o;
    logic         err_o;

    uart_frame_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .tx_byte_o      (tx_byte_o),
        .tx_start_o     (tx_start_o),
        .tx_busy_i      (tx_busy_i),
        .grant_id_o     (grant_id_o),
        .frame_active_o (frame_active_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] pay [4];

    // Transmitter model: busy for 10 clocks starting the cycle after a start.
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    logic dead       = 1'b0;
    always @(posedge clk) begin
        if (tx_start_o && !dead) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy_i = force_busy | (busy_cnt != 0);

    logic [7:0] bytes_q [$];
    int         grants_q [$];
    int         gaps_q [$];
    int         lowrun  = 0;
    int         hot_err = 0;
    int         fa_err  = 0;

    always @(posedge clk) begin
        #1;
        if (tx_start_o) begin
            bytes_q.push_back(tx_byte_o);
            if (!frame_active_o) fa_err++;
        end
        if (req_ready_o != 4'b0) begin
            grants_q.push_back(int'(grant_id_o));
            if (req_ready_o != (4'b1 << grant_id_o)) hot_err++;
        end
        if (!frame_active_o) begin
            lowrun++;
        end else begin
            if (lowrun != 0) gaps_q.push_back(lowrun);
            lowrun = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int w, input int i);
        logic [31:0] p;
        p = pay[w];
        if (i == 0) return 8'h30 + 8'(w);
        if (i == 5) return 8'h0D;
        if (i == 6) return 8'h0A;
        return p[(4-i)*8 +: 8];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outputs",
            {req_ready_o, tx_byte_o, tx_start_o, grant_id_o, frame_active_o, err_o},
            64'h0);
        reset = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] v, input int w, input string tag);
        int n;
        bytes_q.delete();
        grants_q.delete();
        req_valid_i = v;
        n = 0;
        while (req_ready_o == 4'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s ready", tag), req_ready_o, 4'b1 << w);
        chk($sformatf("%s grant_id", tag), grant_id_o, w);
        chk($sformatf("%s active at grant", tag), frame_active_o, 1);
        req_valid_i = 4'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (frame_active_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s frame end", tag), frame_active_o, 0);
    endtask

    task automatic check_frame(input int w, input string tag);
        chk($sformatf("%s byte count", tag), bytes_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s byte%0d", tag, i),
                (i < bytes_q.size()) ? bytes_q[i] : 8'hxx, exp_byte(w, i));
        end
        chk($sformatf("%s ready pulses", tag), grants_q.size(), 1);
    endtask

    task automatic run_frame(input logic [3:0] v, input int w, input string tag);
        start_frame(v, w, tag);
        wait_done(tag);
        check_frame(w, tag);
    endtask

    typedef struct {
        logic [3:0] valid;
        int         winner;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        int exp_order [5];
        vecs[0] = '{4'b0001, 0};
        vecs[1] = '{4'b1111, 1};
        vecs[2] = '{4'b0100, 2};
        vecs[3] = '{4'b1010, 3};
        vecs[4] = '{4'b1010, 1};
        vecs[5] = '{4'b1001, 3};
        vecs[6] = '{4'b1000, 3};
        vecs[7] = '{4'b0110, 1};
        exp_order = '{0, 1, 2, 3, 0};

        pay[0] = 32'h1234ABCD;
        pay[1] = 32'hDEADBEEF;
        pay[2] = 32'h00FF5A01;
        pay[3] = 32'h80000001;
        req_data_i  = {pay[3], pay[2], pay[1], pay[0]};
        req_valid_i = 4'b0;
        reset       = 1'b1;
        @(negedge clk);
        do_reset();

        // All requesters held valid: strict rotation and fixed inter-frame gap.
        grants_q.delete();
        gaps_q.delete();
        req_valid_i = 4'b1111;
        n = 0;
        while (grants_q.size() < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        req_valid_i = 4'b0;
        chk("rr held grant count", grants_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr held order%0d", i),
                (i < grants_q.size()) ? grants_q[i] : -1, exp_order[i]);
        end
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("gap+idle clocks %0d", i),
                (i < gaps_q.size()) ? gaps_q[i] : -1, 17);
        end
        wait_done("rr held");

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].valid, vecs[i].winner, $sformatf("vec%0d", i));
        end

        // Transmitter busy before the first byte: no start until it drops.
        start_frame(4'b0001, 0, "stall");
        force_busy = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start_o) n++;
        end
        chk("stall no start", n, 0);
        force_busy = 1'b0;
        wait_done("stall");
        check_frame(0, "stall");

        // Transmitter never acknowledges the third byte.
        start_frame(4'b1000, 3, "timeout");
        n = 0;
        while (bytes_q.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        dead = 1'b1;
        n = 0;
        while (!err_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout err delay", n, 15);
        chk("timeout active low", frame_active_o, 0);
        @(negedge clk);
        chk("timeout err pulse width", err_o, 0);
        repeat (40) @(negedge clk);
        chk("timeout no 4th start", bytes_q.size(), 3);
        dead = 1'b0;
        run_frame(4'b0100, 2, "post-timeout");

        // Reset while the second payload byte is on the wire.
        start_frame(4'b0010, 1, "midreset");
        n = 0;
        while (bytes_q.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midreset byte2", (bytes_q.size() > 2) ? bytes_q[2] : 8'hxx, 8'hAD);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset outputs",
            {req_ready_o, tx_byte_o, tx_start_o, grant_id_o, frame_active_o, err_o},
            64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset no more starts", bytes_q.size(), 3);
        run_frame(4'b1111, 0, "after reset");

        chk("ready one-hot", hot_err, 0);
        chk("start outside frame", fa_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
